aes_arbiter: RTL and testbench
==============================

AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, WAIT cycles allowed before abort (used only with AES_ARB_TIMEOUT_EN).
REQ-002 One clock; reset is asynchronous and active-low. Ports are listed one per line below.
REQ-003 i_Clk  input  1  clock, all state on rising edge.
REQ-004 i_Rst  input  1  asynchronous, active-low reset.
REQ-005 i_Req0_fStart / i_Req1_fStart  input  1  one-cycle request pulse per requester.
REQ-006 i_Req0_fDec / i_Req1_fDec  input  1  1=decrypt, 0=encrypt, sampled with the pulse.
REQ-007 i_Req0_Key / i_Req1_Key  input  128  key, sampled with the pulse.
REQ-008 i_Req0_Text / i_Req1_Text  input  128  text, sampled with the pulse.
REQ-009 o_Rdy0 / o_Rdy1  output  1  high when that requester has no pending job.
REQ-010 o_Done0 / o_Done1  output  1  one-cycle completion pulse.
REQ-011 o_Res_Text  output  128  result of the last completed job, held until the next completion.
REQ-012 o_Err  output  1  timeout flag, pulsed with o_DoneN.
REQ-013 o_Busy  output  1  FSM not in IDLE.
REQ-014 o_Grant  output  1  index of the requester being served.
REQ-015 o_AES_fStart / o_AES_fDec  output  1 / 1  core start pulse and mode.
REQ-016 o_AES_Key / o_AES_Text  output  128 / 128  core operands.
REQ-017 i_AES_fDone / i_AES_Text  input  1 / 128  core completion pulse and result.

Function
REQ-018 Accepting a request: pulse with o_RdyN=1 latches dec/key/text into slot N and sets pendingN; o_RdyN falls the next cycle.
REQ-019 Ignored requests: a pulse with o_RdyN=0 is ignored and leaves slot contents unchanged.
REQ-020 FSM states: IDLE, START, WAIT, DONE.
REQ-021 IDLE: with any pending slot, grant a slot and copy its operands to the o_AES_* registers, then go to START.
REQ-022 Grant choice: if only one slot is pending, grant it; if both are pending, grant the slot at the round-robin pointer.
REQ-023 START: o_AES_fStart=1 for exactly one cycle, then WAIT. Operands stay stable from START until DONE.
REQ-024 WAIT: on i_AES_fDone, capture i_AES_Text into o_Res_Text, then DONE.
REQ-025 DONE: o_Done[grant]=1 for one cycle; clear pending[grant]; set pointer = ~grant; go to IDLE.
REQ-026 Latency: request pulse at cycle T into an idle block gives START at T+2; o_DoneN comes 2 cycles after i_AES_fDone.
REQ-027 Request during own job: o_RdyN rises the cycle after DONE; a pulse in that cycle is accepted.
REQ-028 Busy-period requests: the other requester may be accepted at any time and is served after the current job.
REQ-029 Stray core done: i_AES_fDone outside WAIT is ignored.
REQ-030 Simultaneous requests into IDLE: granted per pointer; back-to-back jobs alternate, so neither requester can starve.

Reset
REQ-031 On i_Rst=0 asynchronously, clear the following, including mid-job:
- state=IDLE, pointer=0, pending=0;
- all outputs 0 except o_Rdy0=o_Rdy1=1;
- slot registers and o_Res_Text 0.
REQ-032 After reset release, a core done arriving late from an aborted job is ignored (per REQ-029).

Configuration
REQ-033 Macro AES_ARB_TIMEOUT_EN defined:
- a WAIT cycle counter runs;
- if TIMEOUT_CYCLES elapse without i_AES_fDone, enter DONE with o_Err=1;
- o_Res_Text is unchanged on timeout;
- the counter clears on WAIT entry.
REQ-034 Macro absent: no counter, o_Err tied 0, WAIT lasts indefinitely.

Structure
REQ-035 Package aes_arb_pkg holds state encodings, the 128-bit block width constant and the TIMEOUT_CYCLES default.
REQ-036 Sub-module aes_arb_slot (pending flag plus operand buffer, Rdy logic) is instantiated twice; the FSM, arbitration and timeout logic stay in aes_arbiter.

Verification
REQ-037 Single job:
- stimulus: Req0 encrypt, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model done after 12 cycles;
- required: start at T+2, o_Res_Text=69c4e0d86a7b0430d8cdb78070b4c55a, o_Done0 one pulse, o_Rdy0 back high.
REQ-038 Simultaneous requests after reset:
- stimulus: Req0 and Req1 pulse in the same cycle;
- required: Req0 served first, then Req1; o_Grant 0 then 1.
REQ-039 Starvation check:
- stimulus: both requesters re-pulse immediately on each o_Rdy rise for 6 jobs;
- required: grants strictly alternate 0,1,0,1,0,1.
REQ-040 Ignored and stray pulses:
- stimulus: Req0 re-pulses with text 0 while pending; inject i_AES_fDone while IDLE;
- required: original text used; no state change, no done.
REQ-041 Reset mid-job:
- stimulus: assert i_Rst in WAIT, release, then return core done;
- required: all outputs at reset values, late done ignored, a new Req1 job completes normally.
REQ-042 Timeout (macro defined):
- stimulus: TIMEOUT_CYCLES=16, core never answers;
- required: o_Done0 and o_Err pulse together 16 cycles after WAIT entry, o_Res_Text unchanged.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the two-requester AES core arbiter.
package aes_arb_pkg;

    localparam int BLOCK_W         = 128;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic               dec;
        logic [BLOCK_W-1:0] key;
        logic [BLOCK_W-1:0] text;
    } job_t;

endpackage

// File: rtl/aes_arb_slot.sv
// One requester slot: pending flag, operand buffer and ready indication.
module aes_arb_slot
    import aes_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_start,
    input  logic               req_dec,
    input  logic [BLOCK_W-1:0] req_key,
    input  logic [BLOCK_W-1:0] req_text,
    input  logic               clear,
    output logic               rdy,
    output logic               pending,
    output job_t               job
);

    logic pending_reg;
    job_t job_reg;

    // Operands are frozen while a job is pending so the arbiter can copy them later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            job_reg     <= '0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (req_start && !pending_reg) begin
            pending_reg <= 1'b1;
            job_reg     <= {req_dec, req_key, req_text};
        end
    end

    assign rdy     = !pending_reg;
    assign pending = pending_reg;
    assign job     = job_reg;

endmodule

// File: rtl/aes_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters.
// Optional WAIT timeout abort is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Req0_fStart,
    input  logic               i_Req1_fStart,
    input  logic               i_Req0_fDec,
    input  logic               i_Req1_fDec,
    input  logic [BLOCK_W-1:0] i_Req0_Key,
    input  logic [BLOCK_W-1:0] i_Req1_Key,
    input  logic [BLOCK_W-1:0] i_Req0_Text,
    input  logic [BLOCK_W-1:0] i_Req1_Text,
    output logic               o_Rdy0,
    output logic               o_Rdy1,
    output logic               o_Done0,
    output logic               o_Done1,
    output logic [BLOCK_W-1:0] o_Res_Text,
    output logic               o_Err,
    output logic               o_Busy,
    output logic               o_Grant,
    output logic               o_AES_fStart,
    output logic               o_AES_fDec,
    output logic [BLOCK_W-1:0] o_AES_Key,
    output logic [BLOCK_W-1:0] o_AES_Text,
    input  logic               i_AES_fDone,
    input  logic [BLOCK_W-1:0] i_AES_Text
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]         req_start;
    logic [1:0]         req_dec;
    logic [BLOCK_W-1:0] req_key  [2];
    logic [BLOCK_W-1:0] req_text [2];
    logic [1:0]         clear;
    logic [1:0]         rdy;
    logic [1:0]         pending;
    job_t               slot_job [2];

    arb_state_t         state_reg, state_next;
    logic               grant_reg, grant_next;
    logic               ptr_reg;
    logic               load_ops, capture_res, wait_expired;
    logic               aes_dec_reg;
    logic [BLOCK_W-1:0] aes_key_reg, aes_text_reg, res_reg;
    logic [1:0]         done_reg;

    assign req_start   = {i_Req1_fStart, i_Req0_fStart};
    assign req_dec     = {i_Req1_fDec, i_Req0_fDec};
    assign req_key[0]  = i_Req0_Key;
    assign req_key[1]  = i_Req1_Key;
    assign req_text[0] = i_Req0_Text;
    assign req_text[1] = i_Req1_Text;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        // A slot is released in the DONE cycle, so its ready rises the cycle after.
        assign clear[gi] = (state_reg == ST_DONE) && (grant_reg == 1'(gi));

        aes_arb_slot u_slot (
            .clk       (i_Clk),
            .rst_n     (i_Rst),
            .req_start (req_start[gi]),
            .req_dec   (req_dec[gi]),
            .req_key   (req_key[gi]),
            .req_text  (req_text[gi]),
            .clear     (clear[gi]),
            .rdy       (rdy[gi]),
            .pending   (pending[gi]),
            .job       (slot_job[gi])
        );
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        load_ops    = 1'b0;
        capture_res = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|pending) begin
                    grant_next = (&pending) ? ptr_reg : pending[1];
                    load_ops   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (i_AES_fDone) begin
                    capture_res = 1'b1;
                    state_next  = ST_DONE;
                end else if (wait_expired) begin
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 1'b0;
            ptr_reg      <= 1'b0;
            aes_dec_reg  <= 1'b0;
            aes_key_reg  <= '0;
            aes_text_reg <= '0;
            res_reg      <= '0;
            done_reg     <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            done_reg  <= '0;
            if (load_ops) begin
                aes_dec_reg  <= slot_job[grant_next].dec;
                aes_key_reg  <= slot_job[grant_next].key;
                aes_text_reg <= slot_job[grant_next].text;
            end
            if (capture_res) begin
                res_reg <= i_AES_Text;
            end
            if (state_reg == ST_DONE) begin
                done_reg[grant_reg] <= 1'b1;
                ptr_reg             <= ~grant_reg;
            end
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_pend_reg;
    logic             err_reg;

    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // The counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            wait_cnt_reg <= '0;
            err_pend_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
            err_reg      <= (state_reg == ST_DONE) && err_pend_reg;
            if (state_reg == ST_DONE) begin
                err_pend_reg <= 1'b0;
            end else if (state_reg == ST_WAIT && !i_AES_fDone && wait_expired) begin
                err_pend_reg <= 1'b1;
            end
        end
    end

    assign o_Err = err_reg;
`else
    assign wait_expired = 1'b0;
    assign o_Err        = 1'b0;
`endif

    assign o_Rdy0       = rdy[0];
    assign o_Rdy1       = rdy[1];
    assign o_Done0      = done_reg[0];
    assign o_Done1      = done_reg[1];
    assign o_Res_Text   = res_reg;
    assign o_Busy       = (state_reg != ST_IDLE);
    assign o_Grant      = grant_reg;
    assign o_AES_fStart = (state_reg == ST_START);
    assign o_AES_fDec   = aes_dec_reg;
    assign o_AES_Key    = aes_key_reg;
    assign o_AES_Text   = aes_text_reg;

endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter with a transaction-level timing model.
module tb_aes_arbiter;

    localparam int TMO = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_start;
    logic [1:0]   req_dec;
    logic [127:0] req_key [2];
    logic [127:0] req_text [2];
    logic         core_done, stray_done;
    logic [127:0] core_text, stray_text;
    logic         aes_done;
    logic [127:0] aes_res;

    logic         o_Rdy0, o_Rdy1, o_Done0, o_Done1, o_Err, o_Busy, o_Grant;
    logic         o_AES_fStart, o_AES_fDec;
    logic [127:0] o_Res_Text, o_AES_Key, o_AES_Text;

    assign aes_done = core_done | stray_done;
    assign aes_res  = stray_done ? stray_text : core_text;

    aes_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_Req0_fStart(req_start[0]), .i_Req1_fStart(req_start[1]),
        .i_Req0_fDec(req_dec[0]), .i_Req1_fDec(req_dec[1]),
        .i_Req0_Key(req_key[0]), .i_Req1_Key(req_key[1]),
        .i_Req0_Text(req_text[0]), .i_Req1_Text(req_text[1]),
        .o_Rdy0(o_Rdy0), .o_Rdy1(o_Rdy1), .o_Done0(o_Done0), .o_Done1(o_Done1),
        .o_Res_Text(o_Res_Text), .o_Err(o_Err), .o_Busy(o_Busy), .o_Grant(o_Grant),
        .o_AES_fStart(o_AES_fStart), .o_AES_fDec(o_AES_fDec),
        .o_AES_Key(o_AES_Key), .o_AES_Text(o_AES_Text),
        .i_AES_fDone(aes_done), .i_AES_Text(aes_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int grants[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // Stand-in core: fixed answer for the FIPS-197 vector, a cheap reversible mix otherwise.
    function automatic logic [127:0] core_fn(input logic d, input logic [127:0] k, input logic [127:0] t);
        if (!d && k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return {t[63:0], t[127:64]} ^ k ^ {128{d}};
    endfunction

    // ---------------- behavioural model ----------------
    bit           m_pend [2];
    int           m_acc [2];
    logic         m_dec [2];
    logic [127:0] m_key [2], m_text [2];
    bit           m_active, m_have_done, m_gnt, m_ptr, m_pulse_idx, m_pulse_err, m_err_pend;
    int           m_start, m_done_at, m_idle_from, m_pulse_cyc;
    logic         m_cur_dec;
    logic [127:0] m_cur_key, m_cur_text, m_res;

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pend[n] = 0; m_acc[n] = 0; m_dec[n] = 0; m_key[n] = '0; m_text[n] = '0;
        end
        m_active = 0; m_have_done = 0; m_gnt = 0; m_ptr = 0; m_pulse_idx = 0;
        m_pulse_err = 0; m_err_pend = 0; m_start = 0; m_done_at = 0;
        m_idle_from = -100; m_pulse_cyc = -100;
        m_cur_dec = 0; m_cur_key = '0; m_cur_text = '0; m_res = '0;
    endtask

    task automatic model_step(input int c);
        int  nn;
        bit  v0, v1;
        nn = c + 1;
        for (int n = 0; n < 2; n++) begin
            if (req_start[n] && !m_pend[n]) begin
                m_pend[n] = 1; m_acc[n] = c;
                m_dec[n] = req_dec[n]; m_key[n] = req_key[n]; m_text[n] = req_text[n];
            end
        end
        if (m_active && !m_have_done && c > m_start) begin
            if (aes_done) begin
                m_have_done = 1; m_done_at = c + 2; m_err_pend = 0;
                m_res = core_fn(m_cur_dec, m_cur_key, m_cur_text);
            end
`ifdef AES_ARB_TIMEOUT_EN
            else if (c - m_start >= TMO) begin
                m_have_done = 1; m_done_at = c + 2; m_err_pend = 1;
            end
`endif
        end
        if (m_active && m_have_done && nn == m_done_at) begin
            m_pend[m_gnt] = 0; m_ptr = ~m_gnt; m_active = 0; m_idle_from = nn;
            m_pulse_cyc = nn; m_pulse_idx = m_gnt; m_pulse_err = m_err_pend;
        end
        if (!m_active && nn >= m_idle_from + 1) begin
            v0 = m_pend[0] && (m_acc[0] + 2 <= nn);
            v1 = m_pend[1] && (m_acc[1] + 2 <= nn);
            if (v0 || v1) begin
                m_gnt = (v0 && v1) ? m_ptr : v1;
                m_active = 1; m_have_done = 0; m_start = nn;
                m_cur_dec = m_dec[m_gnt]; m_cur_key = m_key[m_gnt]; m_cur_text = m_text[m_gnt];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(cyc);
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rdy0", o_Rdy0, 1); chk("rst_rdy1", o_Rdy1, 1);
                chk("rst_busy", o_Busy, 0); chk("rst_done", {o_Done1, o_Done0}, 0);
                chk("rst_res", o_Res_Text, 0); chk("rst_key", o_AES_Key, 0);
                chk("rst_grant", o_Grant, 0); chk("rst_start", o_AES_fStart, 0);
            end else begin
                chk("rdy0", o_Rdy0, !m_pend[0]);
                chk("rdy1", o_Rdy1, !m_pend[1]);
                chk("busy", o_Busy, m_active);
                chk("aes_start", o_AES_fStart, m_active && cyc == m_start);
                chk("grant", o_Grant, m_gnt);
                chk("aes_dec", o_AES_fDec, m_cur_dec);
                chk("aes_key", o_AES_Key, m_cur_key);
                chk("aes_text", o_AES_Text, m_cur_text);
                chk("done0", o_Done0, cyc == m_pulse_cyc && m_pulse_idx == 0);
                chk("done1", o_Done1, cyc == m_pulse_cyc && m_pulse_idx == 1);
                chk("err", o_Err, cyc == m_pulse_cyc && m_pulse_err);
                chk("res_text", o_Res_Text, m_res);
                if (o_AES_fStart) grants.push_back(int'(o_Grant));
                if (o_Done0 || o_Done1)
                    $display("cycle %0d: job done req%0d result %h err %b", cyc, o_Done1, o_Res_Text, o_Err);
            end
        end
    end

    // ---------------- core model ----------------
    bit           core_auto = 0;
    int           core_lat  = 0;
    int           lat;
    logic         cd;
    logic [127:0] ck, ct;

    initial begin
        core_done = 0; core_text = '0;
        forever begin
            @(negedge clk);
            if (core_auto && rst_n && o_AES_fStart) begin
                lat = (core_lat > 0) ? core_lat : int'($urandom_range(1, 14));
                cd = o_AES_fDec; ck = o_AES_Key; ct = o_AES_Text;
                repeat (lat) @(posedge clk);
                #1;
                if (rst_n) begin
                    core_done = 1; core_text = core_fn(cd, ck, ct);
                    @(posedge clk); #1;
                    core_done = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 0; req_start = 0; stray_done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic pulse(input int n, input logic d, input logic [127:0] k, input logic [127:0] t);
        req_start[n] = 1; req_dec[n] = d; req_key[n] = k; req_text[n] = t;
    endtask

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_AES_fStart) begin at = cyc; return; end
        end
        chk("wait_start_timeout", 0, 1);
    endtask

    task automatic wait_done(input int idx, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((idx == 0) ? o_Done0 : o_Done1) begin at = cyc; return; end
        end
        chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_Rdy0 && o_Rdy1 && !o_Busy) return;
        end
        chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired @cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    int t0, s, d;

    initial begin
        rst_n = 0; req_start = 0; req_dec = 0; stray_done = 0; stray_text = '0;
        for (int n = 0; n < 2; n++) begin req_key[n] = '0; req_text[n] = '0; end

        // single FIPS-197 job
        do_reset();
        core_auto = 1; core_lat = 12;
        pulse(0, 0, FIPS_KEY, FIPS_PT); t0 = cyc; tick(); req_start = 0;
        wait_start(20, s);
        chk("start_latency", 32'(s), 32'(t0 + 2));
        wait_done(0, 100, d);
        chk("done_latency", 32'(d), 32'(s + 14));
        chk("fips_result", o_Res_Text, FIPS_CT);
        chk("rdy0_back_high", o_Rdy0, 1);
        @(negedge clk);
        chk("done0_single_pulse", o_Done0, 0);
        tick();

        // simultaneous requests after reset
        do_reset();
        core_lat = 0; grants.delete();
        pulse(0, 0, 128'h11, 128'h22); pulse(1, 1, 128'h33, 128'h44); tick(); req_start = 0;
        wait_done(0, 100, d);
        wait_done(1, 100, d);
        chk("simul_grant_count", 32'(grants.size()), 2);
        chk("simul_grant_first", 32'(grants[0]), 0);
        chk("simul_grant_second", 32'(grants[1]), 1);
        tick();

        // both requesters re-pulse whenever ready
        do_reset();
        grants.delete();
        for (int i = 0; i < 2000 && grants.size() < 6; i++) begin
            req_start[0] = o_Rdy0; req_start[1] = o_Rdy1;
            for (int n = 0; n < 2; n++) begin
                req_dec[n] = 1'($urandom); req_text[n] = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        req_start = 0;
        wait_idle(300);
        for (int i = 0; i < 6; i++) chk("alternate_grant", 32'(grants[i]), 32'(i % 2));
        tick();

        // ignored re-pulse and stray core done
        do_reset();
        core_lat = 5;
        pulse(0, 0, 128'h0, 128'h1); tick();
        pulse(0, 0, 128'h0, 128'h0); tick(); req_start = 0;
        wait_done(0, 100, d);
        chk("ignored_repulse", o_Res_Text, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        wait_idle(50); tick();
        stray_done = 1; stray_text = {$urandom, $urandom, $urandom, $urandom}; tick(); stray_done = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_busy", o_Busy, 0);
            chk("stray_done", {o_Done1, o_Done0}, 0);
            chk("stray_res", o_Res_Text, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        end
        tick();

        // reset in the middle of a job, then a late core done
        do_reset();
        core_auto = 0; core_lat = 0;
        pulse(0, 1, 128'h55, 128'h66); tick(); req_start = 0;
        wait_start(20, s);
        repeat (3) tick();
        chk("busy_before_reset", o_Busy, 1);
        #2 rst_n = 0;
        #1;
        chk("midjob_rst_busy", o_Busy, 0); chk("midjob_rst_rdy0", o_Rdy0, 1);
        chk("midjob_rst_key", o_AES_Key, 0); chk("midjob_rst_text", o_AES_Text, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) tick();
        stray_done = 1; stray_text = {$urandom, $urandom, $urandom, $urandom}; tick(); stray_done = 0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_busy", o_Busy, 0);
            chk("late_done_pulse", {o_Done1, o_Done0}, 0);
            chk("late_done_res", o_Res_Text, 0);
        end
        tick();
        core_auto = 1;
        pulse(1, 1, 128'h0, 128'h2); tick(); req_start = 0;
        wait_done(1, 100, d);
        chk("post_reset_job", o_Res_Text, 128'hFFFF_FFFF_FFFF_FFFD_FFFF_FFFF_FFFF_FFFF);
        tick();

`ifdef AES_ARB_TIMEOUT_EN
        // core never answers
        do_reset();
        core_auto = 0;
        pulse(0, 0, 128'h7, 128'h8); tick(); req_start = 0;
        wait_start(20, s);
        wait_done(0, 60, d);
        chk("timeout_done_cycle", 32'(d), 32'(s + TMO + 2));
        chk("timeout_err", o_Err, 1);
        chk("timeout_res_kept", o_Res_Text, 0);
        tick();
        core_auto = 1;
`endif

        // randomized traffic with stray dones while idle
        do_reset();
        core_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++) begin
                req_start[n] = ($urandom_range(0, 2) == 0);
                req_dec[n]   = 1'($urandom);
                req_key[n]   = {$urandom, $urandom, $urandom, $urandom};
                req_text[n]  = {$urandom, $urandom, $urandom, $urandom};
            end
            stray_done = !o_Busy && ($urandom_range(0, 15) == 0);
            stray_text = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        req_start = 0; stray_done = 0;
        wait_idle(300);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
